alu_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one combinational MIPS ALU (3-bit aluOp, two 32-bit operands, 32-bit result).
Each requester issues an operation over a valid/ready handshake and gets its result over a separate valid/ready response channel.
Only one operation is in flight at a time. Operands and op are registered before reaching the ALU. The result is captured into a response register.
The block sits between the ALU and its clients, for example the execute stage and a multi-cycle helper unit.

---
 rtl/alu_arbiter_if.sv | 53 +++++
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Handshake and ALU-side signal bundle for alu_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the ALU.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;

    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_in0;
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_result;

    logic             busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        input  alu_result,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
        output alu_op, alu_in0, alu_in1,
        output busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        output alu_result,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
        input  alu_op, alu_in0, alu_in1,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// One operation in flight: accept, hold operands SETTLE cycles, capture result, wait for consumer.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 1
) (
    input logic         clk,
    input logic         rst_n,
    alu_arbiter_if.slave bus
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             owner;
    logic [CW-1:0]    cnt;
    logic [2:0]       alu_op_q;
    logic [WIDTH-1:0] alu_in0_q;
    logic [WIDTH-1:0] alu_in1_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;
    logic             busy_q;

    logic             grant0;
    logic             grant1;
    logic             rsp_taken;

    // On contention the requester that did not win last time is preferred.
    always_comb begin
        grant0    = bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1    = bus.req1_valid && (!bus.req0_valid || !last_grant);
        rsp_taken = owner ? bus.rsp1_ready : bus.rsp0_ready;
    end

    assign bus.req0_ready = rst_n && (state == IDLE) && grant0;
    assign bus.req1_ready = rst_n && (state == IDLE) && grant1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_in0    = alu_in0_q;
    assign bus.alu_in1    = alu_in1_q;
    assign bus.busy       = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            cnt          <= '0;
            alu_op_q     <= '0;
            alu_in0_q    <= '0;
            alu_in1_q    <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        alu_op_q   <= grant1 ? bus.req1_op : bus.req0_op;
                        alu_in0_q  <= grant1 ? bus.req1_a  : bus.req0_a;
                        alu_in1_q  <= grant1 ? bus.req1_b  : bus.req0_b;
                        owner      <= grant1;
                        last_grant <= grant1;
                        cnt        <= SETTLE_INIT;
                        busy_q     <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // The zero flag is derived here rather than taken from the ALU.
                    if (cnt == '0) begin
                        result_q     <= bus.alu_result;
                        zero_q       <= (bus.alu_result == '0);
                        rsp0_valid_q <= !owner;
                        rsp1_valid_q <= owner;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_taken) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter; two instances (SETTLE=1 and SETTLE=3)
// share one stimulus stream and are each compared against a transaction-level model.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        s_v0, s_v1, s_r0, s_r1;
    logic [2:0]  s_op0, s_op1;
    logic [31:0] s_a0, s_b0, s_a1, s_b1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    alu_arbiter_if #(.WIDTH(32)) bus1 ();
    alu_arbiter_if #(.WIDTH(32)) bus3 ();

    assign bus1.req0_valid = s_v0;  assign bus3.req0_valid = s_v0;
    assign bus1.req0_op    = s_op0; assign bus3.req0_op    = s_op0;
    assign bus1.req0_a     = s_a0;  assign bus3.req0_a     = s_a0;
    assign bus1.req0_b     = s_b0;  assign bus3.req0_b     = s_b0;
    assign bus1.req1_valid = s_v1;  assign bus3.req1_valid = s_v1;
    assign bus1.req1_op    = s_op1; assign bus3.req1_op    = s_op1;
    assign bus1.req1_a     = s_a1;  assign bus3.req1_a     = s_a1;
    assign bus1.req1_b     = s_b1;  assign bus3.req1_b     = s_b1;
    assign bus1.rsp0_ready = s_r0;  assign bus3.rsp0_ready = s_r0;
    assign bus1.rsp1_ready = s_r1;  assign bus3.rsp1_ready = s_r1;
    assign bus1.alu_result = alu_model(bus1.alu_op, bus1.alu_in0, bus1.alu_in1);
    assign bus3.alu_result = alu_model(bus3.alu_op, bus3.alu_in0, bus3.alu_in1);

    alu_arbiter #(.WIDTH(32), .SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    alu_arbiter #(.WIDTH(32), .SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    // Observed outputs gathered so both instances can be checked in one loop.
    logic        o_busy[2], o_rv0[2], o_rv1[2], o_zero[2], o_rdy0[2], o_rdy1[2];
    logic [31:0] o_res[2], o_in0[2], o_in1[2];
    logic [2:0]  o_op[2];

    assign o_busy[0] = bus1.busy;       assign o_busy[1] = bus3.busy;
    assign o_rv0[0]  = bus1.rsp0_valid; assign o_rv0[1]  = bus3.rsp0_valid;
    assign o_rv1[0]  = bus1.rsp1_valid; assign o_rv1[1]  = bus3.rsp1_valid;
    assign o_zero[0] = bus1.rsp_zero;   assign o_zero[1] = bus3.rsp_zero;
    assign o_rdy0[0] = bus1.req0_ready; assign o_rdy0[1] = bus3.req0_ready;
    assign o_rdy1[0] = bus1.req1_ready; assign o_rdy1[1] = bus3.req1_ready;
    assign o_res[0]  = bus1.rsp_result; assign o_res[1]  = bus3.rsp_result;
    assign o_in0[0]  = bus1.alu_in0;    assign o_in0[1]  = bus3.alu_in0;
    assign o_in1[0]  = bus1.alu_in1;    assign o_in1[1]  = bus3.alu_in1;
    assign o_op[0]   = bus1.alu_op;     assign o_op[1]   = bus3.alu_op;

    // Transaction model: an accepted op occupies the unit for 'left' cycles, then its
    // result waits for the owner's ready.
    bit          m_busy[2];
    int          m_left[2];
    bit          m_owner[2];
    bit          m_last[2];
    bit          m_rv[2];
    bit          m_zero[2];
    logic [31:0] m_res[2], m_in0[2], m_in1[2];
    logic [2:0]  m_op[2];

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_left[d] = 0; m_owner[d] = 0; m_last[d] = 1;
            m_rv[d] = 0; m_zero[d] = 0; m_res[d] = '0; m_in0[d] = '0; m_in1[d] = '0;
            m_op[d] = '0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("busy[%0d]", d), 32'(o_busy[d]), 32'(m_busy[d]));
            checkOutput($sformatf("rsp0_valid[%0d]", d), 32'(o_rv0[d]), 32'(m_rv[d] && !m_owner[d]));
            checkOutput($sformatf("rsp1_valid[%0d]", d), 32'(o_rv1[d]), 32'(m_rv[d] && m_owner[d]));
            checkOutput($sformatf("rsp_result[%0d]", d), o_res[d], m_res[d]);
            checkOutput($sformatf("rsp_zero[%0d]", d), 32'(o_zero[d]), 32'(m_zero[d]));
            checkOutput($sformatf("alu_op[%0d]", d), 32'(o_op[d]), 32'(m_op[d]));
            checkOutput($sformatf("alu_in0[%0d]", d), o_in0[d], m_in0[d]);
            checkOutput($sformatf("alu_in1[%0d]", d), o_in1[d], m_in1[d]);
        end
    endtask

    // Drives one cycle of inputs, checks ready, advances the model across the next
    // rising edge and checks the registered outputs on the falling edge.
    task automatic applyStimulus(input logic v0, input logic [2:0] op0, input logic [31:0] a0,
                                 input logic [31:0] b0, input logic v1, input logic [2:0] op1,
                                 input logic [31:0] a1, input logic [31:0] b1,
                                 input logic r0, input logic r1);
        bit g0, g1;
        s_v0 = v0; s_op0 = op0; s_a0 = a0; s_b0 = b0;
        s_v1 = v1; s_op1 = op1; s_a1 = a1; s_b1 = b1;
        s_r0 = r0; s_r1 = r1;
        #1;
        for (int d = 0; d < 2; d++) begin
            g0 = !m_busy[d] && v0 && (!v1 || m_last[d]);
            g1 = !m_busy[d] && v1 && (!v0 || !m_last[d]);
            checkOutput($sformatf("req0_ready[%0d]", d), 32'(o_rdy0[d]), 32'(g0));
            checkOutput($sformatf("req1_ready[%0d]", d), 32'(o_rdy1[d]), 32'(g1));
            if (!m_busy[d]) begin
                if (g0 || g1) begin
                    m_owner[d] = g1; m_last[d] = g1;
                    m_op[d]  = g1 ? op1 : op0;
                    m_in0[d] = g1 ? a1 : a0;
                    m_in1[d] = g1 ? b1 : b0;
                    m_busy[d] = 1; m_left[d] = settle_of(d);
                end
            end else if (m_left[d] > 0) begin
                m_left[d]--;
                if (m_left[d] == 0) begin
                    m_res[d]  = alu_model(m_op[d], m_in0[d], m_in1[d]);
                    m_zero[d] = (m_res[d] == 0);
                    m_rv[d]   = 1;
                end
            end else if (m_owner[d] ? r1 : r0) begin
                m_rv[d] = 0; m_busy[d] = 0;
            end
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic idle_step(input logic r0, input logic r1);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, r0, r1);
    endtask

    task automatic drain();
        int budget = 30;
        while ((m_busy[0] || m_busy[1]) && budget > 0) begin
            idle_step(1'b1, 1'b1);
            budget--;
        end
        if (budget == 0) checkOutput("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        s_v0 = 0; s_v1 = 0; s_r0 = 0; s_r1 = 0;
        #1;
        model_reset();
        check_state();
        checkOutput("rst_busy", 32'(o_busy[0]), 32'd0);
        checkOutput("rst_in0", o_in0[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        s_v0 = 0; s_v1 = 0; s_r0 = 0; s_r1 = 0;
        s_op0 = 0; s_op1 = 0; s_a0 = 0; s_b0 = 0; s_a1 = 0; s_b1 = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_state();
        rst_n = 1'b1;

        // Single AND from requester 0
        applyStimulus(1'b1, 3'b000, 32'h33, 32'hCC, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        idle_step(1'b0, 1'b0);
        checkOutput("t1_rsp0_valid", 32'(o_rv0[0]), 32'd1);
        checkOutput("t1_result", o_res[0], 32'd0);
        checkOutput("t1_zero", 32'(o_zero[0]), 32'd1);
        checkOutput("t1_alu_op", 32'(o_op[0]), 32'd0);
        checkOutput("t1_alu_in0", o_in0[0], 32'h33);
        drain();

        // Single OR from requester 1
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 3'b001, 32'hF0, 32'hAA, 1'b0, 1'b0);
        idle_step(1'b0, 1'b0);
        checkOutput("t2_rsp1_valid", 32'(o_rv1[0]), 32'd1);
        checkOutput("t2_rsp0_valid", 32'(o_rv0[0]), 32'd0);
        checkOutput("t2_result", o_res[0], 32'hFA);
        checkOutput("t2_zero", 32'(o_zero[0]), 32'd0);
        drain();

        // Both requesters continuously valid: grants alternate
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b1, 3'b010, 32'd5, 32'd7, 1'b1, 3'b010, 32'hFFFF_FFFF, 32'd1,
                          1'b1, 1'b1);
        drain();

        // Response back-pressure with requester 1 waiting
        applyStimulus(1'b1, 3'b110, 32'd10, 32'd3, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 3'b001, 32'h1, 32'h2, 1'b0, 1'b0);
        checkOutput("t4_rsp0_valid", 32'(o_rv0[0]), 32'd1);
        checkOutput("t4_result", o_res[0], 32'd7);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 3'b001, 32'h1, 32'h2, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 3'b001, 32'h1, 32'h2, 1'b1, 1'b0);
        checkOutput("t4_owner1_busy", 32'(o_busy[0]), 32'd1);
        drain();

        // Asynchronous reset while an SLT is executing
        applyStimulus(1'b1, 3'b111, 32'd1, 32'd2, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        reset_pulse();
        for (int i = 0; i < 4; i++) idle_step(1'b1, 1'b1);

        // Long settle on the SETTLE=3 instance
        applyStimulus(1'b1, 3'b110, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        idle_step(1'b0, 1'b0);
        idle_step(1'b0, 1'b0);
        checkOutput("t6_rsp0_early", 32'(o_rv0[1]), 32'd0);
        checkOutput("t6_alu_op_held", 32'(o_op[1]), 32'd6);
        idle_step(1'b0, 1'b0);
        checkOutput("t6_rsp0_valid", 32'(o_rv0[1]), 32'd1);
        checkOutput("t6_result", o_res[1], 32'd0);
        checkOutput("t6_zero", 32'(o_zero[1]), 32'd1);
        drain();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), rand_operand(),
                          rand_operand(), $urandom_range(0, 2) != 0,
                          3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
                          $urandom_range(0, 4) < 3, $urandom_range(0, 4) < 3);
            if (i == 300) reset_pulse();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
